// File: rtl/prng_hex_display.sv
`default_nettype none
// ============================================================================
// Module : prng_hex_display
// Brief  : Tick-driven 8-bit Fibonacci LFSR shown on two active-low 7-seg digits
// Rev    : 1.0
// ============================================================================
module prng_hex_display #(
   parameter int unsigned DIV  = 32'd50000000,
   parameter logic [7:0]  SEED = 8'h01
) (
   input  logic       CLK,
   input  logic       rst_n,
   input  logic       EN,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic       clk1hz
);

   localparam logic [31:0] c_LAST = DIV - 32'd1;
   // An all-zero seed would lock the LFSR, so it is promoted to 01.
   localparam logic [7:0]  c_SEED = (SEED == 8'h00) ? 8'h01 : SEED;

   logic [31:0] r_cnt;
   logic [7:0]  r_q;
   logic        w_tick;
   logic        w_fb;
   logic [6:0]  w_hex [2];

   assign w_tick = EN && (r_cnt == c_LAST);
   assign clk1hz = w_tick;

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (EN) begin
         r_cnt <= (r_cnt == c_LAST) ? 32'd0 : r_cnt + 32'd1;
      end
   end

   // Taps for x^8 + x^6 + x^5 + x^4 + 1.
   assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_q <= c_SEED;
      end else if (r_q == 8'h00) begin
         r_q <= 8'h01;
      end else if (w_tick) begin
         r_q <= {r_q[6:0], w_fb};
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      s = 7'h7F;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   generate
      for (genvar i = 0; i < 2; i++) begin : g_digit
         assign w_hex[i] = seg7(r_q[4*i +: 4]);
      end
   endgenerate

   assign HEX0 = w_hex[0];
   assign HEX1 = w_hex[1];

endmodule
`default_nettype wire

// File: tb/tb_prng_hex_display.sv
`default_nettype none
// Scoreboard bench: two DUTs (DIV=4 and DIV=1) under randomized enable/reset,
// checked against a sequence table built from the LFSR polynomial.
module tb_prng_hex_display;

   typedef struct {
      int         cyc;
      logic [7:0] q;
   } exp_t;

   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic       clk = 1'b0;
   logic [1:0] rst_v = 2'b00;
   logic [1:0] en_v  = 2'b00;
   logic       stb_v [2];
   logic [6:0] h0 [2];
   logic [6:0] h1 [2];

   int         cyc = 0;
   int         vectors = 0;
   int         errors = 0;
   exp_t       sb [2][$];
   exp_t       mon_e;
   logic [7:0] seq [256];
   int         en_cnt [2];
   int         idx [2];
   int         divs [2] = '{4, 1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prng_hex_display #(.DIV(4), .SEED(8'h01)) dut4 (
      .CLK(clk), .rst_n(rst_v[0]), .EN(en_v[0]),
      .HEX0(h0[0]), .HEX1(h1[0]), .clk1hz(stb_v[0]));

   prng_hex_display #(.DIV(1), .SEED(8'h01)) dut1 (
      .CLK(clk), .rst_n(rst_v[1]), .EN(en_v[1]),
      .HEX0(h0[1]), .HEX1(h1[1]), .clk1hz(stb_v[1]));

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_disp(input int d);
      chk($sformatf("hex0_dut%0d", d), {1'b0, h0[d]}, {1'b0, SEG[seq[idx[d]][3:0]]});
      chk($sformatf("hex1_dut%0d", d), {1'b0, h1[d]}, {1'b0, SEG[seq[idx[d]][7:4]]});
   endtask

   // Drive one cycle; the model predicts ticks by counting enabled cycles since reset.
   task automatic step(input logic [1:0] r, input logic [1:0] e);
      rst_v = r;
      en_v  = e;
      for (int d = 0; d < 2; d++) begin
         if (!r[d]) begin
            en_cnt[d] = 0;
            idx[d]    = 0;
         end else if (e[d]) begin
            en_cnt[d]++;
            if (en_cnt[d] % divs[d] == 0) begin
               sb[d].push_back(exp_t'{cyc: cyc, q: seq[idx[d]]});
               idx[d] = (idx[d] + 1) % 255;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe must match the oldest expected tick in cycle and value.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         while (sb[d].size() > 0 && sb[d][0].cyc < cyc) begin
            vectors++;
            errors++;
            $display("FAIL missed_tick_dut%0d: got no strobe, required strobe at cycle %0d", d, sb[d][0].cyc);
            void'(sb[d].pop_front());
         end
         if (stb_v[d] && rst_v[d]) begin
            vectors++;
            if (sb[d].size() == 0 || sb[d][0].cyc != cyc) begin
               errors++;
               $display("FAIL spurious_tick_dut%0d: got strobe at cycle %0d, required none", d, cyc);
            end else begin
               mon_e = sb[d].pop_front();
               if (h0[d] !== SEG[mon_e.q[3:0]] || h1[d] !== SEG[mon_e.q[7:4]]) begin
                  errors++;
                  $display("FAIL tick_value_dut%0d: got hex1=%h hex0=%h required hex1=%h hex0=%h (q=%h)",
                           d, h1[d], h0[d], SEG[mon_e.q[7:4]], SEG[mon_e.q[3:0]], mon_e.q);
               end
            end
         end
      end
      if (rst_v[1]) begin
         vectors++;
         if (h0[1] === 7'h40 && h1[1] === 7'h40) begin
            errors++;
            $display("FAIL lockup_dut1: got q=00, required nonzero");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      seq[0] = 8'h01;
      for (int i = 1; i < 256; i++) seq[i] = {seq[i-1][6:0], ^(seq[i-1] & 8'hB8)};
      en_cnt = '{0, 0};
      idx    = '{0, 0};

      @(posedge clk);
      #1;
      // Reset with EN high on the DIV=4 unit.
      step(2'b00, 2'b01);
      step(2'b00, 2'b01);
      chk("rst_hex0", {1'b0, h0[0]}, 8'h79);
      chk("rst_hex1", {1'b0, h1[0]}, 8'h40);
      chk("rst_clk1hz", {7'b0, stb_v[0]}, 8'h00);
      chk_disp(1);

      // Cadence (DIV=4) and raw sequence (DIV=1).
      for (int i = 0; i < 12; i++) step(2'b11, 2'b11);
      chk_disp(0);
      chk_disp(1);

      // Mid-run reset of the DIV=1 unit; DIV=4 idles for that cycle.
      step(2'b01, 2'b00);
      chk_disp(1);
      chk("midrst_hex0", {1'b0, h0[1]}, 8'h79);

      // Freeze: 2 enabled, 10 disabled, then resume on DIV=4.
      for (int i = 0; i < 2; i++)  step(2'b11, 2'b11);
      for (int i = 0; i < 10; i++) step(2'b11, 2'b10);
      chk_disp(0);
      for (int i = 0; i < 4; i++)  step(2'b11, 2'b11);

      // Reset while the DIV=4 tick condition is present.
      while (en_cnt[0] % 4 != 3) step(2'b11, 2'b11);
      step(2'b10, 2'b11);
      chk("rst_tick_hex0", {1'b0, h0[0]}, 8'h79);
      chk("rst_tick_hex1", {1'b0, h1[0]}, 8'h40);

      // Full period on DIV=1.
      for (int i = 0; i < 300; i++) step(2'b11, 2'b11);
      chk_disp(1);

      // Randomized enables with occasional resets.
      for (int i = 0; i < 500; i++) begin
         step({($urandom_range(0, 39) != 0), ($urandom_range(0, 39) != 0)},
              2'($urandom_range(0, 3)));
      end

      for (int i = 0; i < 4; i++) step(2'b11, 2'b00);
      chk_disp(0);
      chk_disp(1);
      chk("sb_empty_dut4", 8'(sb[0].size()), 8'h00);
      chk("sb_empty_dut1", 8'(sb[1].size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
